mdc_bin: RTL and testbench
==========================

Name: mdc_bin

Overview:
- Parametrised successor of the 8-bit GCD (mdc) unit. Computes GCD of two WIDTH-bit unsigned operands using the binary (Stein) algorithm: shifts and subtracts only, no divider.
- Replaces the single enable/busy interface with valid/ready handshakes on input and output, so upstream and downstream stages can stall it.
- Adds a zero-operand flag and a per-operation cycle count.
- Sits between an operand source (stimulus/bus bridge) and a result sink in the GCD datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal ≥ 2.
- CYC_W, 8, width of cycles_o; counter saturates at 2**CYC_W-1.

Ports:
- clk_i       in   1      clock, rising edge
- rstn_i      in   1      reset, asynchronous, active-low
- in_valid_i  in   1      operands valid
- in_ready_o  out  1      block can accept operands
- dtx_i       in   WIDTH  operand X
- dty_i       in   WIDTH  operand Y
- out_valid_o out  1      result valid
- out_ready_i in   1      sink accepts result
- dt_o        out  WIDTH  GCD result
- zero_o      out  1      at least one operand was 0
- cycles_o    out  CYC_W  cycles spent in SHIFT+REDUCE for this result
- busy_o      out  1      state != IDLE

Behaviour:

Reset:
- rstn_i low asynchronously forces state=IDLE and clears internal regs a, b, k and the counter.
- Output reset values: dt_o=0, zero_o=0, cycles_o=0, out_valid_o=0, busy_o=0, in_ready_o=1.
- Reset mid-operation abandons the operation; no result is produced.

FSM states: IDLE, SHIFT, REDUCE, DONE.

Output decode:
- in_ready_o = (state==IDLE).
- out_valid_o = (state==DONE).
- busy_o = (state!=IDLE).

IDLE:
- On in_valid_i && in_ready_o, latch a=dtx_i, b=dty_i, k=0, count=0.
- If a==0 or b==0: dt_o=a|b, zero_o=1, cycles_o=0, go DONE. Both zero gives dt_o=0, zero_o=1.
- Otherwise: zero_o=0, go SHIFT.

SHIFT (count+1 every cycle):
- a and b both even: a>>=1, b>>=1, k+=1, stay.
- Else: go REDUCE, a and b unchanged.

REDUCE (count+1 every cycle, including the final one). One action per cycle, in priority order:
1. a==b: dt_o=a<<k (truncated to WIDTH; cannot overflow because the result ≤ the original operands), cycles_o=count+1 (saturating), go DONE.
2. a even: a>>=1.
3. b even: b>>=1.
4. a>b: a=(a-b)>>1.
5. else: b=(b-a)>>1.
- Subtraction is WIDTH-bit unsigned and never underflows.

DONE:
- dt_o, zero_o and cycles_o are held stable while out_valid_o=1 && !out_ready_i.
- On out_ready_i, go IDLE. Outputs keep their last values until the next DONE.
- in_valid_i is ignored outside IDLE. There is one bubble cycle between results (no accept in the DONE→IDLE cycle).

Latency bound (nonzero operands):
- cycles_o ≤ 3*WIDTH+1.
- in-accept to out_valid_o = cycles_o+1 clocks.

Test Plan:
- WIDTH=8, X=48, Y=18, out_ready_i=1 → dt_o=6, zero_o=0, cycles_o=7, out_valid_o for exactly 1 cycle, then in_ready_o=1 the next cycle.
- WIDTH=8, X=128, Y=128 → dt_o=128, cycles_o=9. Also X=255, Y=255 → dt_o=255, cycles_o=2.
- X=0, Y=12 → dt_o=12, zero_o=1, cycles_o=0. Also X=0, Y=0 → dt_o=0, zero_o=1.
- Backpressure, X=48, Y=18: hold out_ready_i=0 for 5 cycles after out_valid_o rises and drive in_valid_i=1 with X=9, Y=6 → dt_o=6 stays stable, in_ready_o=0, and the second pair is accepted only after the DONE handshake plus the return to IDLE. Its result is dt_o=3.
- Reset mid-op: pulse rstn_i low asynchronously (between clock edges) during REDUCE of 48/18 → all outputs go to reset values immediately; next pair 35/21 → dt_o=7.
- WIDTH=16, CYC_W=6: 1000 random pairs checked against a golden GCD model → dt_o and zero_o correct, cycles_o ≤ 49 (saturating at 63), and no lost or duplicated results under random in_valid_i/out_ready_i.

Source files
------------

// File: rtl/mdc_bin_if.sv
// Handshake bundle for the binary GCD unit: operand channel in, result
// channel out, plus status. The source/sink side uses the master modport.
interface mdc_bin_if #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] dtx_i;
    logic [WIDTH-1:0] dty_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] dt_o;
    logic             zero_o;
    logic [CYC_W-1:0] cycles_o;
    logic             busy_o;

    modport master (
        output in_valid_i, dtx_i, dty_i, out_ready_i,
        input  in_ready_o, out_valid_o, dt_o, zero_o, cycles_o, busy_o
    );

    modport slave (
        input  in_valid_i, dtx_i, dty_i, out_ready_i,
        output in_ready_o, out_valid_o, dt_o, zero_o, cycles_o, busy_o
    );
endinterface

// File: rtl/mdc_bin.sv
// Binary (Stein) GCD unit with valid/ready on operands and result.
// SHIFT strips common factors of two (counted in k), REDUCE walks a/b down
// to equality with halvings and halved differences, and the result is
// a << k. A saturating counter reports the SHIFT+REDUCE cycles per result.
module mdc_bin #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    mdc_bin_if.slave   bus
);
    // k never exceeds WIDTH-1 for a nonzero WIDTH-bit operand
    localparam int K_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REDUCE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CYC_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dt_q, dt_d;
    logic             zero_q, zero_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic [CYC_W-1:0] count_inc;

    // Saturating increment of the per-operation cycle counter
    assign count_inc = (count_q == {CYC_W{1'b1}}) ? count_q : count_q + CYC_W'(1);

    // Next-state and datapath decisions for one Stein step per cycle
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        count_d  = count_q;
        dt_d     = dt_q;
        zero_d   = zero_q;
        cycles_d = cycles_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    a_d     = bus.dtx_i;
                    b_d     = bus.dty_i;
                    k_d     = '0;
                    count_d = '0;
                    if (bus.dtx_i == '0 || bus.dty_i == '0) begin
                        // gcd(0, y) = y; both zero yields 0
                        dt_d     = bus.dtx_i | bus.dty_i;
                        zero_d   = 1'b1;
                        cycles_d = '0;
                        state_d  = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                count_d = count_inc;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end else begin
                    state_d = REDUCE;
                end
            end

            REDUCE: begin
                count_d = count_inc;
                if (a_q == b_q) begin
                    // Result never exceeds the operands, so the shift cannot overflow
                    dt_d     = a_q << k_q;
                    cycles_d = count_inc;
                    state_d  = DONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // Both odd here, so the difference is even and halving is exact
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end

            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            count_q  <= '0;
            dt_q     <= '0;
            zero_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            count_q  <= count_d;
            dt_q     <= dt_d;
            zero_q   <= zero_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.dt_o        = dt_q;
    assign bus.zero_o      = zero_q;
    assign bus.cycles_o    = cycles_q;
endmodule

// File: tb/tb_mdc_bin.sv
// Bench for mdc_bin: directed cases on an 8-bit instance, randomised traffic
// with backpressure on a 16-bit instance, both scored through queues of
// expected results built from a Euclid reference model.
module tb_mdc_bin;
    logic clk = 1'b0;
    logic rstn;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   abort = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mdc_bin_if #(.WIDTH(8),  .CYC_W(8)) bus8 ();
    mdc_bin_if #(.WIDTH(16), .CYC_W(6)) bus16 ();

    mdc_bin #(.WIDTH(8), .CYC_W(8)) dut8 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus8)
    );

    mdc_bin #(.WIDTH(16), .CYC_W(6)) dut16 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus16)
    );

    typedef struct {
        logic [15:0] dt;
        logic        zero;
        int          cyc;   // -1: only the latency bound is known
        int          acc;   // cycle count at the accepting negedge
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gcd_ref(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check_reset8(input string tag);
        check({tag, "_in_ready"},  bus8.in_ready_o,  1);
        check({tag, "_out_valid"}, bus8.out_valid_o, 0);
        check({tag, "_busy"},      bus8.busy_o,      0);
        check({tag, "_dt"},        bus8.dt_o,        0);
        check({tag, "_zero"},      bus8.zero_o,      0);
        check({tag, "_cycles"},    bus8.cycles_o,    0);
    endtask

    // Present one operand pair at a negedge; returns one negedge after acceptance
    task automatic send8(input logic [7:0] x, input logic [7:0] y, output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        bus8.dtx_i = x;
        bus8.dty_i = y;
        bus8.in_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus8.in_ready_o) begin
                ok = 1'b1;
                acc = cyc_cnt;
                break;
            end
            @(negedge clk);
        end
        check("send8_ready", ok, 1);
        if (ok) @(negedge clk);
        bus8.in_valid_i = 1'b0;
    endtask

    // Wait for a result and score it against the head of the queue
    task automatic recv8();
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus8.out_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("recv8_valid", seen, 1);
        if (seen) begin
            check("sb8_pending", q8.size() > 0, 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("dt8", bus8.dt_o, e.dt);
                check("zero8", bus8.zero_o, e.zero);
                if (e.cyc >= 0) begin
                    check("cycles8", bus8.cycles_o, e.cyc);
                    check("latency8", cyc_cnt - e.acc, e.cyc + 1);
                end
            end
        end
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] dt, input logic zero, input int cyc);
        int acc;
        send8(x, y, acc);
        q8.push_back('{dt: 16'(dt), zero: zero, cyc: cyc, acc: acc});
        recv8();
        @(negedge clk);
    endtask

    task automatic driver16();
        logic [15:0] x, y, base;
        int          acc, mode;
        bit          ok;
        for (int n = 0; n < 1000 && !abort; n++) begin
            mode = $urandom_range(0, 9);
            x = 16'($urandom());
            y = 16'($urandom());
            case (mode)
                0: x = '0;
                1: y = '0;
                2: begin
                    base = 16'($urandom_range(1, 255));
                    x = base * 16'($urandom_range(1, 255));
                    y = base * 16'($urandom_range(1, 255));
                end
                3: y = x;
                4: begin
                    x = x << $urandom_range(0, 8);
                    y = y << $urandom_range(0, 8);
                end
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus16.dtx_i = x;
            bus16.dty_i = y;
            bus16.in_valid_i = 1'b1;
            ok = 1'b0;
            acc = 0;
            for (int i = 0; i < 400; i++) begin
                if (bus16.in_ready_o) begin
                    ok = 1'b1;
                    acc = cyc_cnt;
                    break;
                end
                @(negedge clk);
            end
            check("drv16_ready", ok, 1);
            if (!ok) begin
                bus16.in_valid_i = 1'b0;
                abort = 1'b1;
                break;
            end
            q16.push_back('{dt: gcd_ref(x, y), zero: (x == 0 || y == 0), cyc: -1, acc: acc});
            @(negedge clk);
            bus16.in_valid_i = 1'b0;
        end
    endtask

    task automatic collector16();
        int          got, budget;
        bit          holding;
        logic [15:0] prev_dt;
        logic [5:0]  prev_cyc;
        exp_t        e;
        got = 0;
        budget = 0;
        holding = 1'b0;
        prev_dt = '0;
        prev_cyc = '0;
        while (got < 1000 && !abort && budget < 80000) begin
            @(negedge clk);
            budget++;
            if (bus16.out_valid_o) begin
                if (!holding) begin
                    check("sb16_pending", q16.size() > 0, 1);
                    if (q16.size() > 0) begin
                        e = q16.pop_front();
                        check("dt16", bus16.dt_o, e.dt);
                        check("zero16", bus16.zero_o, e.zero);
                        if (e.zero) check("cycles16_zero", bus16.cycles_o, 0);
                        else        check("cycles16_bound", bus16.cycles_o <= 49, 1);
                        check("latency16", cyc_cnt - e.acc, bus16.cycles_o + 1);
                    end
                    holding = 1'b1;
                    prev_dt = bus16.dt_o;
                    prev_cyc = bus16.cycles_o;
                end else begin
                    check("hold16_dt", bus16.dt_o, prev_dt);
                    check("hold16_cycles", bus16.cycles_o, prev_cyc);
                end
                bus16.out_ready_i = ($urandom_range(0, 3) != 0);
                if (bus16.out_ready_i) begin
                    holding = 1'b0;
                    got++;
                end
            end else begin
                bus16.out_ready_i = 1'($urandom_range(0, 1));
            end
        end
        if (got < 1000) abort = 1'b1;
        check("got16", got, 1000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        rstn = 1'b0;
        bus8.in_valid_i = 1'b0;  bus8.dtx_i = '0;  bus8.dty_i = '0;  bus8.out_ready_i = 1'b1;
        bus16.in_valid_i = 1'b0; bus16.dtx_i = '0; bus16.dty_i = '0; bus16.out_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset8("rst");
        check("rst16_in_ready", bus16.in_ready_o, 1);
        check("rst16_out_valid", bus16.out_valid_o, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 48/18: result, latency, single-cycle valid, outputs held in IDLE
        send8(8'd48, 8'd18, acc);
        check("t1_busy", bus8.busy_o, 1);
        check("t1_in_ready", bus8.in_ready_o, 0);
        q8.push_back('{dt: 16'd6, zero: 1'b0, cyc: 7, acc: acc});
        recv8();
        @(negedge clk);
        check("t1_valid_drop", bus8.out_valid_o, 0);
        check("t1_ready_back", bus8.in_ready_o, 1);
        check("t1_dt_held", bus8.dt_o, 6);

        // Equal operands and zero operands
        run8(8'd128, 8'd128, 8'd128, 1'b0, 9);
        run8(8'd255, 8'd255, 8'd255, 1'b0, 2);
        run8(8'd0,   8'd12,  8'd12,  1'b1, 0);
        run8(8'd0,   8'd0,   8'd0,   1'b1, 0);
        run8(8'd20,  8'd0,   8'd20,  1'b1, 0);

        // Backpressure: result held, new operands refused until after DONE->IDLE
        bus8.out_ready_i = 1'b0;
        send8(8'd48, 8'd18, acc);
        q8.push_back('{dt: 16'd6, zero: 1'b0, cyc: 7, acc: acc});
        recv8();
        bus8.dtx_i = 8'd9;
        bus8.dty_i = 8'd6;
        bus8.in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus8.out_valid_o, 1);
            check("bp_dt", bus8.dt_o, 6);
            check("bp_cycles", bus8.cycles_o, 7);
            check("bp_in_ready", bus8.in_ready_o, 0);
        end
        bus8.out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_bubble_valid", bus8.out_valid_o, 0);
        check("bp_bubble_ready", bus8.in_ready_o, 1);
        q8.push_back('{dt: 16'd3, zero: 1'b0, cyc: 4, acc: cyc_cnt});
        @(negedge clk);
        bus8.in_valid_i = 1'b0;
        recv8();
        @(negedge clk);

        // Asynchronous reset during REDUCE abandons the operation
        send8(8'd48, 8'd18, acc);
        repeat (2) @(negedge clk);
        check("mid_busy", bus8.busy_o, 1);
        #2 rstn = 1'b0;
        #1 check_reset8("async_rst");
        @(negedge clk);
        check_reset8("rst_held");
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus8.out_valid_o, 0);
        run8(8'd35, 8'd21, 8'd7, 1'b0, 4);
        check("sb8_empty", q8.size(), 0);

        // Random traffic on the 16-bit instance
        fork
            driver16();
            collector16();
        join
        check("sb16_empty", q16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
